red_accum: RTL
==============

# red_accum

Sequential accumulator that sits directly downstream of the byte-reduction unit. It consumes a stream of 16-bit signed reduction results and sums a programmed number of them into one 16-bit saturating total. It returns that total, plus a sticky overflow flag, over a valid/ready handshake. Its typical use is a multi-word reduction such as a sum across a vector of operand pairs before writeback.

## Interface
- CNT_W, default 8: width of the length/count field. The maximum run length is 2^CNT_W-1.

- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- len  input  CNT_W  number of results to accumulate; sampled with start
- in_vld  input  1  in_data is valid
- in_data  input  16  signed reduction result (sign-extended 9-bit value from the reduction stage; treated as full 16-bit two's complement)
- in_rdy  output  1  block accepts in_data this cycle
- out_vld  output  1  out_data/out_ovfl hold the final result
- out_data  output  16  saturated signed accumulation
- out_ovfl  output  1  saturation occurred at least once during the run
- out_rdy  input  1  consumer takes the result
- busy  output  1  high in ACCUM and DONE

## Operation
- States:
  - IDLE:
    - in_rdy=0, out_vld=0.
    - start=1 with len!=0 → ACCUM; acc←0, rem←len, ovfl←0.
    - start=1 with len==0 → DONE; acc←0, ovfl←0.
  - ACCUM:
    - in_rdy=1. A beat transfers when in_vld&&in_rdy.
    - On a beat: acc←sat(acc+in_data), rem←rem-1.
    - A beat with rem==1 → DONE.
    - in_vld low: hold all state, with no timeout.
  - DONE:
    - in_rdy=0, out_vld=1.
    - out_data=acc and out_ovfl=ovfl stay stable until out_rdy=1, then → IDLE.
- start is ignored outside IDLE. len is captured only on an accepted start.
- Arithmetic:
  - Form a 17-bit sum of sign-extended acc and in_data.
  - If sum[16]!=sum[15], saturate: a positive overflow gives 0x7FFF, a negative overflow gives 0x8000. Set ovfl.
  - ovfl is sticky for the run. acc continues from its saturated value; a later opposite-sign input can move it off the rail.
- Outputs are registered or decoded purely from state. There is no combinational path from in_vld or out_rdy to any output.

## Timing
- Reset values (cycle after rst=1 is sampled): state IDLE, acc=0, rem=0, ovfl=0.
- Resulting outputs after reset: out_vld=0, out_data=0x0000, out_ovfl=0, in_rdy=0, busy=0.
- rst has priority over every other input in every state. A reset mid-run discards the partial sum and pending result.
- Start latency: start is accepted at edge N, and in_rdy=1 from cycle N+1.
- Result latency: the last beat is accepted at edge M, and out_vld=1 in cycle M+1.
- Minimum run time: a run of len beats with in_vld held high takes len+1 cycles from start to out_vld.
- len==0: out_vld=1 the cycle after start, with out_data=0.
- Handshake completion: out_rdy sampled high in DONE gives out_vld=0 next cycle.
- Back-to-back runs: the next start is accepted no earlier than one cycle after the result handshake.
- A start asserted in the same cycle as the DONE handshake is lost.

## Test plan
- Reset: hold rst 2 cycles with random other inputs → out_vld=0, in_rdy=0, busy=0, out_data=0x0000, out_ovfl=0. Repeat the reset while in ACCUM → IDLE the next cycle.
- Basic sum: len=4, inputs 0x0010, 0x0020, 0xFFF0, 0x0005 → out_data=0x0025, out_ovfl=0, out_vld exactly 1 cycle after the 4th beat.
- Positive saturation and recovery: len=3, inputs 0x7000, 0x7000, 0xF000 → after beat 2 acc=0x7FFF; final out_data=0x6FFF, out_ovfl=1.
- Negative saturation: len=2, inputs 0x8000, 0xFFFF → out_data=0x8000, out_ovfl=1.
- Zero length: start with len=0 → out_vld=1 next cycle, out_data=0x0000, out_ovfl=0, in_rdy never asserted.
- Handshake stalls:
  - len=3 with in_vld low for 2 cycles between beats, inputs 0x00FF, 0xFF00, 0x0001 → out_data=0x0000.
  - Hold out_rdy=0 for 3 cycles → out_vld and out_data stable throughout.
  - Pulse start during DONE → ignored, no new run begins.

Source files
------------

// File: rtl/red_accum.sv
// Saturating accumulator for a programmed number of 16-bit signed reduction results.
// The total and a sticky overflow flag are returned over a valid/ready handshake.
module red_accum #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_vld,
  input  logic [15:0]      in_data,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [15:0]      out_data,
  output logic             out_ovfl,
  input  logic             out_rdy,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [15:0]      acc, acc_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic             ovfl, ovfl_nx;
  logic [16:0]      sum;
  logic [15:0]      sat;
  logic             sat_hit;

  // 17-bit sum; bits 16 and 15 disagree exactly when the 16-bit result overflowed.
  always_comb begin
    sum     = {acc[15], acc} + {in_data[15], in_data};
    sat_hit = sum[16] ^ sum[15];
    if (!sat_hit)
      sat = sum[15:0];
    else if (sum[16])
      sat = 16'h8000;
    else
      sat = 16'h7FFF;
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    rem_nx   = rem;
    ovfl_nx  = ovfl;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_nx  = '0;
          ovfl_nx = 1'b0;
          rem_nx  = len;
          state_nx = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_vld) begin
          acc_nx  = sat;
          ovfl_nx = ovfl | sat_hit;
          rem_nx  = rem - 1'b1;
          if (rem == {{(CNT_W-1){1'b0}}, 1'b1})
            state_nx = DONE;
        end
      end
      DONE: begin
        if (out_rdy)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      ovfl  <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      rem   <= rem_nx;
      ovfl  <= ovfl_nx;
    end
  end

  assign in_rdy   = (state == ACCUM);
  assign out_vld  = (state == DONE);
  assign busy     = (state != IDLE);
  assign out_data = acc;
  assign out_ovfl = ovfl;

endmodule
